// File: rtl/result_memory_writer.sv
// Captures four result words in one parallel write and streams them out by address 0..3.
// Latency: first beat is presented the cycle after wr is accepted; done pulses the cycle after the last beat is accepted.
// Backpressure: beat held stable while out_ready is low; wr is ignored while busy.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   wr, WriteData1..4          capture strobe and the four words (address 0..3)
//   busy                       high while streaming or signalling done
//   out_valid/out_ready        beat handshake toward the result sink
//   out_addr, out_data         address and data of the current beat (0 when not valid)
//   done                       one-cycle pulse after the last beat is accepted
module result_memory_writer #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [WIDTH-1:0]  WriteData1,
    input  logic [WIDTH-1:0]  WriteData2,
    input  logic [WIDTH-1:0]  WriteData3,
    input  logic [WIDTH-1:0]  WriteData4,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [WIDTH-1:0]  out_data,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_idx;
    logic [ADDR_W-1:0]  w_idx_nxt;
    logic               w_capture;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    // State and index register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Storage only changes on an accepted capture, so it keeps the last
    // dump's words after DONE until the next capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_capture) begin
            r_mem[0] <= WriteData1;
            r_mem[1] <= WriteData2;
            r_mem[2] <= WriteData3;
            r_mem[3] <= WriteData4;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // Index stops at the last address; the transfer ends via DONE,
                // never by wrapping to address 0.
                if (out_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Output decode from registered state only; data is forced to 0 when
    // no beat is valid so the sink never sees stale words.
    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        out_addr  = '0;
        out_data  = '0;
        done      = 1'b0;
        case (r_state)
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = r_idx;
                out_data  = r_mem[r_idx];
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_result_memory_writer.sv
// Bench for result_memory_writer: directed scenarios followed by random traffic.
// Every cycle the DUT outputs are compared against a transaction-level model.
// Model tracks the words captured, beats remaining and a pending done pulse.
module tb_result_memory_writer;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [31:0] WriteData1, WriteData2, WriteData3, WriteData4;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_addr;
    logic [31:0] out_data;
    logic        done;

    result_memory_writer #(.WIDTH(32), .DEPTH(4), .ADDR_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wr),
        .WriteData1 (WriteData1),
        .WriteData2 (WriteData2),
        .WriteData3 (WriteData3),
        .WriteData4 (WriteData4),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: words of the current dump, beats still to deliver,
    // and whether the done pulse is due this cycle.
    logic [31:0] m_words [4];
    int          m_left = 0;
    bit          m_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic t_rst, input logic t_wr, input logic t_rdy,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        if (!t_rst) begin
            m_left = 0;
            m_done = 1'b0;
            for (int i = 0; i < 4; i++) m_words[i] = 32'h0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (t_rdy) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end
        end else if (t_wr) begin
            m_words[0] = a;
            m_words[1] = b;
            m_words[2] = c;
            m_words[3] = d;
            m_left     = 4;
        end
    endtask

    task automatic check_outputs();
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        e_valid = (m_left > 0);
        e_addr  = e_valid ? 32'(4 - m_left) : 32'h0;
        e_data  = e_valid ? m_words[4 - m_left] : 32'h0;
        check("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
        check("out_addr",  {30'h0, out_addr},  e_addr);
        check("out_data",  out_data,           e_data);
        check("done",      {31'h0, done},      {31'h0, m_done});
        check("busy",      {31'h0, busy},      {31'h0, (e_valid || m_done)});
    endtask

    // Drive inputs for one cycle, let the edge happen, update model, compare.
    task automatic tick(input logic t_rst, input logic t_wr, input logic t_rdy,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        rst_n      = t_rst;
        wr         = t_wr;
        out_ready  = t_rdy;
        WriteData1 = a;
        WriteData2 = b;
        WriteData3 = c;
        WriteData4 = d;
        @(posedge clk);
        model_edge(t_rst, t_wr, t_rdy, a, b, c, d);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic t_rdy);
        tick(1'b1, 1'b0, t_rdy, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic wr_std();
        tick(1'b1, 1'b1, 1'b1, 32'h0000000A, 32'h00000014, 32'h0000001E, 32'h00000028);
    endtask

    int t0;
    int done_cnt;
    int last_beat;
    int first_beat;

    initial begin
        // Reset, then idle
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) idle(1'b1);

        // Full dump with ready high: wr-to-done is 5 cycles
        t0 = cyc;
        wr_std();
        for (int k = 0; k < 20 && !done; k++) idle(1'b1);
        check("lat_full", 32'(cyc - t0), 32'd5);
        idle(1'b1);
        check("busy_after_done", {31'h0, busy}, 32'h0);

        // Backpressure on beat 1 for 3 cycles: wr-to-done is 8 cycles
        t0 = cyc;
        wr_std();
        idle(1'b1);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            check("stall_addr", {30'h0, out_addr}, 32'd1);
            check("stall_data", out_data, 32'h00000014);
        end
        for (int k = 0; k < 20 && !done; k++) idle(1'b1);
        check("lat_stall", 32'(cyc - t0), 32'd8);
        idle(1'b1);

        // wr while busy (during beat 2) is ignored; exactly one done pulse
        done_cnt = 0;
        wr_std();
        idle(1'b1);
        check("beat2_addr", {30'h0, out_addr}, 32'd1);
        tick(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("beat2_data", out_data, 32'h0000001E);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, k == 1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
            if (done) done_cnt++;
        end
        check("done_count", 32'(done_cnt), 32'd1);

        // Reset during beat 1
        done_cnt = 0;
        wr_std();
        idle(1'b1);
        tick(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        check("rst_mid_valid", {31'h0, out_valid}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            idle(1'b1);
            if (done) done_cnt++;
        end
        check("rst_mid_nodone", 32'(done_cnt), 32'd0);
        tick(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4);
        check("post_rst_beat0", out_data, 32'h1);
        for (int k = 0; k < 6; k++) idle(1'b1);

        // Reset and wr in the same cycle: nothing captured
        tick(1'b0, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8);
        idle(1'b1);
        check("rst_wr_valid", {31'h0, out_valid}, 32'h0);

        // Back-to-back dumps: gap of 2 cycles between last and first beat
        last_beat  = -1;
        first_beat = -1;
        wr_std();
        for (int k = 0; k < 20 && !done; k++) begin
            if (out_valid && out_addr == 2'd3) last_beat = cyc;
            idle(1'b1);
        end
        idle(1'b1);
        tick(1'b1, 1'b1, 1'b1, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        if (out_valid && out_addr == 2'd0) first_beat = cyc;
        check("b2b_gap", 32'(first_beat - last_beat - 1), 32'd2);
        check("b2b_data", out_data, 32'hA1);
        for (int k = 0; k < 6; k++) idle(1'b1);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            tick(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) < 7),
                 $urandom, $urandom, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
